// File: rtl/cam_frame_writer.sv
// Tags captured camera pixels with linear frame-buffer addresses and streams
// {addr,pixel} through a small FIFO to a valid/ready memory write port.
module cam_frame_writer #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              end_frame,
  input  logic              end_line,
  input  logic              new_pixel,
  input  logic [15:0]       pixel,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic              line_err
);

  localparam int XW = $clog2(H_RES + 1);
  localparam int YW = $clog2(V_RES + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XW-1:0] H_MAX  = XW'(H_RES);
  localparam logic [YW-1:0] V_MAX  = YW'(V_RES);
  localparam logic [CW-1:0] DEPTH  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FLUSH} state_t;

  state_t              state;
  logic [XW-1:0]       x;
  logic [YW-1:0]       y;
  logic [ADDR_W-1:0]   addr;

  logic [ADDR_W+15:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]       wptr;
  logic [PW-1:0]       rptr;
  logic [CW-1:0]       count;

  logic                in_range;
  logic                push_req;
  logic                fifo_full;
  logic                push;
  logic                pop;
  logic [XW-1:0]       x_after;

  assign in_range  = (x < H_MAX) && (y < V_MAX);
  assign push_req  = (state == CAPTURE) && new_pixel && in_range;
  assign fifo_full = (count == DEPTH);
  assign push      = push_req && !fifo_full;
  assign pop       = wr_valid && wr_ready;
  // The pixel of a coincident new_pixel+end_line counts toward the line length.
  assign x_after   = (new_pixel && (x < H_MAX)) ? x + 1'b1 : x;

  assign wr_valid  = (count != '0);
  assign {wr_addr, wr_data} = mem[rptr];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {addr, pixel};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // addr tracks y*H_RES+x incrementally; short lines leave it behind on purpose.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      addr       <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      line_err   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            state    <= ARMED;
            overflow <= 1'b0;
            line_err <= 1'b0;
          end
        end
        ARMED: begin
          if (end_frame) begin
            state <= CAPTURE;
            x     <= '0;
            y     <= '0;
            addr  <= '0;
          end
        end
        CAPTURE: begin
          if (push_req) addr <= addr + 1'b1;
          if (push_req && fifo_full) overflow <= 1'b1;
          if (end_line) begin
            if ((y < V_MAX) && (x_after != H_MAX)) line_err <= 1'b1;
            x <= '0;
            if (y < V_MAX) y <= y + 1'b1;
          end else begin
            x <= x_after;
          end
          if (end_frame) state <= FLUSH;
        end
        FLUSH: begin
          if (count == '0) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_frame_writer.sv
// Bench for cam_frame_writer: a 4x2 instance for corner cases and a 40x24
// instance for overflow and random-backpressure scoreboard checks.
module tb_cam_frame_writer;

  localparam int H_B = 40;
  localparam int V_B = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        s_rst = 1'b1, s_cap = 1'b0, s_ef = 1'b0, s_el = 1'b0, s_np = 1'b0, s_rdy = 1'b1;
  logic [15:0] s_px = 16'h0;
  logic        s_valid, s_busy, s_fd, s_ov, s_le;
  logic [3:0]  s_addr;
  logic [15:0] s_data;

  logic        b_rst = 1'b1, b_cap = 1'b0, b_ef = 1'b0, b_el = 1'b0, b_np = 1'b0, b_rdy = 1'b0;
  logic        b_rand = 1'b0, b_rdy_fix = 1'b0;
  logic [15:0] b_px = 16'h0;
  logic        b_valid, b_busy, b_fd, b_ov, b_le;
  logic [9:0]  b_addr;
  logic [15:0] b_data;

  cam_frame_writer #(.H_RES(4), .V_RES(2), .ADDR_W(4), .FIFO_DEPTH(16)) u_small (
    .clk(clk), .rst(s_rst), .capture(s_cap), .end_frame(s_ef), .end_line(s_el),
    .new_pixel(s_np), .pixel(s_px), .wr_valid(s_valid), .wr_ready(s_rdy),
    .wr_addr(s_addr), .wr_data(s_data), .busy(s_busy), .frame_done(s_fd),
    .overflow(s_ov), .line_err(s_le));

  cam_frame_writer #(.H_RES(H_B), .V_RES(V_B), .ADDR_W(10), .FIFO_DEPTH(16)) u_big (
    .clk(clk), .rst(b_rst), .capture(b_cap), .end_frame(b_ef), .end_line(b_el),
    .new_pixel(b_np), .pixel(b_px), .wr_valid(b_valid), .wr_ready(b_rdy),
    .wr_addr(b_addr), .wr_data(b_data), .busy(b_busy), .frame_done(b_fd),
    .overflow(b_ov), .line_err(b_le));

  int tests = 0;
  int fails = 0;

  logic [19:0] s_q[$], s_exp[$];
  logic [25:0] b_q[$], b_exp[$];
  int          s_fd_cnt = 0, b_fd_cnt = 0;
  logic        b_stall_prev = 1'b0;
  logic [9:0]  b_addr_prev = '0;
  logic [15:0] b_data_prev = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Backpressure on the large instance is either fixed or a fair coin per cycle.
  always @(posedge clk) begin
    #1;
    b_rdy = b_rand ? 1'($urandom_range(0, 1)) : b_rdy_fix;
  end

  always @(negedge clk) begin
    if (s_valid && s_rdy) s_q.push_back({s_addr, s_data});
    if (s_fd) s_fd_cnt++;
    if (b_valid && b_rdy) b_q.push_back({b_addr, b_data});
    if (b_fd) b_fd_cnt++;
    if (b_stall_prev)
      checkOutput("stall_hold", {5'd0, b_valid, b_addr, b_data}, {5'd0, 1'b1, b_addr_prev, b_data_prev});
    b_stall_prev = b_valid && !b_rdy;
    b_addr_prev  = b_addr;
    b_data_prev  = b_data;
  end

  task automatic applyStimulus(input bit big, input logic cap, input logic ef, input logic el,
                               input logic np, input logic [15:0] px);
    @(posedge clk);
    #1;
    if (big) begin
      b_cap = cap; b_ef = ef; b_el = el; b_np = np; b_px = px;
    end else begin
      s_cap = cap; s_ef = ef; s_el = el; s_np = np; s_px = px;
    end
  endtask

  task automatic idleCycles(input bit big, input int n);
    for (int i = 0; i < n; i++) applyStimulus(big, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic waitDone(input bit big, input int target, input string name);
    for (int c = 0; c < 2000 && (big ? b_fd_cnt : s_fd_cnt) < target; c++) begin
      @(negedge clk);
      #1;
    end
    idleCycles(big, 4);
    checkOutput(name, big ? b_fd_cnt : s_fd_cnt, target);
  endtask

  task automatic compareQueues(input bit big, input string name);
    int n_act, n_exp;
    n_act = big ? b_q.size() : s_q.size();
    n_exp = big ? b_exp.size() : s_exp.size();
    checkOutput({name, "_count"}, n_act, n_exp);
    for (int i = 0; i < n_act && i < n_exp; i++) begin
      if (big) checkOutput($sformatf("%s_wr[%0d]", name, i), 32'(b_q[i]), 32'(b_exp[i]));
      else     checkOutput($sformatf("%s_wr[%0d]", name, i), 32'(s_q[i]), 32'(s_exp[i]));
    end
    if (big) begin b_q.delete(); b_exp.delete(); end
    else     begin s_q.delete(); s_exp.delete(); end
  endtask

  typedef struct {
    logic        cap, ef, el, np;
    logic [15:0] px;
    logic        ev;
    logic [3:0]  ea;
    logic [15:0] ed;
    logic        eb, efd;
  } vec_t;

  function automatic vec_t mk(input logic cap, input logic ef, input logic el, input logic np,
                              input logic [15:0] px, input logic ev, input logic [3:0] ea,
                              input logic [15:0] ed, input logic eb, input logic efd);
    vec_t v;
    v.cap = cap; v.ef = ef; v.el = el; v.np = np; v.px = px;
    v.ev = ev; v.ea = ea; v.ed = ed; v.eb = eb; v.efd = efd;
    return v;
  endfunction

  initial begin
    vec_t        tbl[14];
    int          base, len, fd0;
    bit          co, last_line, exp_le;
    logic [15:0] d;

    // One 4x2 frame, cycle by cycle: outputs seen in a row reflect earlier rows.
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 1'b1, 4'd0, 16'd1, 1'b1, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 16'd3, 1'b1, 4'd1, 16'd2, 1'b1, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 16'd4, 1'b1, 4'd2, 16'd3, 1'b1, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 16'd5, 1'b1, 4'd3, 16'd4, 1'b1, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 16'd6, 1'b1, 4'd4, 16'd5, 1'b1, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 16'd7, 1'b1, 4'd5, 16'd6, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 16'd8, 1'b1, 4'd6, 16'd7, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 4'd7, 16'd8, 1'b1, 1'b0);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    s_rst = 1'b0;
    b_rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_small", {s_valid, s_busy, s_fd, s_ov, s_le}, 5'b0);
    checkOutput("reset_big",   {b_valid, b_busy, b_fd, b_ov, b_le}, 5'b0);

    $display("[TB] test 1: 4x2 frame from vector table");
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      {s_cap, s_ef, s_el, s_np, s_px} = {tbl[i].cap, tbl[i].ef, tbl[i].el, tbl[i].np, tbl[i].px};
      @(negedge clk);
      checkOutput($sformatf("t1_valid[%0d]", i), 32'(s_valid), 32'(tbl[i].ev));
      checkOutput($sformatf("t1_busy[%0d]", i),  32'(s_busy),  32'(tbl[i].eb));
      checkOutput($sformatf("t1_done[%0d]", i),  32'(s_fd),    32'(tbl[i].efd));
      checkOutput($sformatf("t1_flags[%0d]", i), {s_ov, s_le}, 32'd0);
      if (tbl[i].ev) begin
        checkOutput($sformatf("t1_addr[%0d]", i), 32'(s_addr), 32'(tbl[i].ea));
        checkOutput($sformatf("t1_data[%0d]", i), 32'(s_data), 32'(tbl[i].ed));
      end
    end
    idleCycles(1'b0, 2);
    s_q.delete();

    $display("[TB] test 3: short and long lines");
    fd0 = s_fd_cnt;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 1; i <= 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0 + (i == 3), 1'b1, 16'(i));
    for (int i = 4; i <= 9; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0 + (i == 9), 1'b1, 16'(i));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    idleCycles(1'b0, 1);
    waitDone(1'b0, fd0 + 1, "t3_done");
    for (int i = 0; i < 7; i++) s_exp.push_back({4'(i), 16'(i + 1)});
    compareQueues(1'b0, "t3");
    checkOutput("t3_line_err", 32'(s_le), 32'd1);
    checkOutput("t3_overflow", 32'(s_ov), 32'd0);

    $display("[TB] test 4: armed pixels and capture while busy");
    fd0 = s_fd_cnt;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00AA);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00BB);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    idleCycles(1'b0, 1);
    @(negedge clk);
    checkOutput("t4_armed_nowrite", 32'(s_valid), 32'd0);
    checkOutput("t4_err_cleared", 32'(s_le), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2);
    idleCycles(1'b0, 1);
    @(negedge clk);
    checkOutput("t4_err_set", 32'(s_le), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    idleCycles(1'b0, 1);
    @(negedge clk);
    checkOutput("t4_cap_ignored", {s_busy, s_le, s_ov}, 3'b110);
    for (int i = 3; i <= 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0 + (i == 6), 1'b1, 16'(i));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    idleCycles(1'b0, 1);
    waitDone(1'b0, fd0 + 1, "t4_done");
    for (int i = 0; i < 6; i++) s_exp.push_back({4'(i), 16'(i + 1)});
    compareQueues(1'b0, "t4");
    checkOutput("t4_line_err_kept", 32'(s_le), 32'd1);

    $display("[TB] test 5: reset mid-capture");
    s_rdy = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'(16'h50 + i));
    idleCycles(1'b0, 1);
    @(negedge clk);
    checkOutput("t5_buffered", {s_valid, s_busy}, 2'b11);
    fd0 = s_fd_cnt;
    @(posedge clk);
    #1 s_rst = 1'b1;
    @(posedge clk);
    #1 s_rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_after_rst", {s_valid, s_busy, s_fd}, 3'b000);
    s_rdy = 1'b1;
    idleCycles(1'b0, 8);
    checkOutput("t5_no_done", s_fd_cnt, fd0);
    checkOutput("t5_no_writes", s_q.size(), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 1; i <= 8; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0 + (i % 4 == 0), 1'b1, 16'(i));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    idleCycles(1'b0, 1);
    waitDone(1'b0, fd0 + 1, "t5_done");
    for (int i = 0; i < 8; i++) s_exp.push_back({4'(i), 16'(i + 1)});
    compareQueues(1'b0, "t5");
    checkOutput("t5_flags", {s_ov, s_le}, 2'b00);

    $display("[TB] test 2: overflow under full backpressure");
    fd0 = b_fd_cnt;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'(16'h100 + i));
    idleCycles(1'b1, 1);
    @(negedge clk);
    checkOutput("t2_held", {b_valid, b_ov, b_busy}, 3'b111);
    checkOutput("t2_no_writes", b_q.size(), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    idleCycles(1'b1, 1);
    b_rdy_fix = 1'b1;
    waitDone(1'b1, fd0 + 1, "t2_done");
    for (int i = 0; i < 16; i++) b_exp.push_back({10'(i), 16'(16'h100 + i)});
    compareQueues(1'b1, "t2");
    checkOutput("t2_overflow_sticky", 32'(b_ov), 32'd1);

    $display("[TB] test 6: random frame with random backpressure");
    fd0 = b_fd_cnt;
    b_rand = 1'b1;
    base   = 0;
    exp_le = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    idleCycles(1'b1, 1);
    @(negedge clk);
    checkOutput("t6_overflow_cleared", 32'(b_ov), 32'd0);
    for (int y = 0; y < V_B + 2; y++) begin
      len       = ($urandom_range(0, 1) == 1) ? H_B : int'($urandom_range(H_B - 2, H_B + 2));
      last_line = (y == V_B + 1);
      co        = !last_line && ($urandom_range(0, 1) == 1);
      for (int i = 0; i < len; i++) begin
        d = 16'($urandom);
        applyStimulus(1'b1, 1'b0, 1'b0, co && (i == len - 1), 1'b1, d);
        if (y < V_B && i < H_B) b_exp.push_back({10'(base + i), d});
        idleCycles(1'b1, 3);
      end
      if (!co) applyStimulus(1'b1, 1'b0, last_line, 1'b1, 1'b0, 16'h0);
      if (y < V_B) begin
        if (len < H_B) exp_le = 1'b1;
        base += (len < H_B) ? len : H_B;
      end
    end
    idleCycles(1'b1, 1);
    waitDone(1'b1, fd0 + 1, "t6_done");
    compareQueues(1'b1, "t6");
    checkOutput("t6_overflow", 32'(b_ov), 32'd0);
    checkOutput("t6_line_err", 32'(b_le), 32'(exp_le));
    checkOutput("t6_idle", 32'(b_busy), 32'd0);
    b_rand = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
